// File: rtl/riscv_pkg.sv
// Shared constants and the fetch FSM state type for the single-cycle RISC-V core.
package riscv_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    TRAP
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Architectural PC register with load enable and the +4 incrementer feeding PC_mux.
module pc_reg #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VECTOR;
    end else if (load) begin
      pc <= d;
    end
  end

  // Wraps modulo 2^XLEN by construction.
  assign pc_plus4 = pc + XLEN'(4);

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch: PC register, single-outstanding imem handshake, instruction hold
// register for decode, and a sticky trap on a misaligned committed PC.
module pc_fetch_unit #(
  parameter int              XLEN         = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = riscv_pkg::RESET_VECTOR,
  parameter logic [31:0]     NOP_INSTR    = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] PC_next,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCplus4,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     instr,
  output logic            instr_valid,
  input  logic            instr_ack,
  output logic            misaligned
);

  import riscv_pkg::fetch_state_t;
  import riscv_pkg::IDLE;
  import riscv_pkg::REQ;
  import riscv_pkg::WAIT;
  import riscv_pkg::HOLD;
  import riscv_pkg::TRAP;

  fetch_state_t state, state_next;
  logic         pc_load;
  logic         next_misaligned;

  assign next_misaligned = (PC_next[1:0] != 2'b00);

  pc_reg #(
    .XLEN        (XLEN),
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pc_load),
    .d       (PC_next),
    .pc      (PC),
    .pc_plus4(PCplus4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    case (state)
      IDLE: state_next = REQ;
      REQ:  if (imem_req_ready) state_next = WAIT;
      WAIT: if (imem_rsp_valid) state_next = HOLD;
      HOLD: begin
        if (instr_ack) begin
          pc_load    = 1'b1;
          state_next = next_misaligned ? TRAP : REQ;
        end
      end
      TRAP:    state_next = TRAP;
      default: state_next = IDLE;
    endcase
  end

  // Responses are only captured in WAIT, so stale data after a reset is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      if (state == WAIT && imem_rsp_valid) begin
        instr       <= imem_rsp_data;
        instr_valid <= 1'b1;
      end else if (state == HOLD && instr_ack) begin
        instr       <= NOP_INSTR;
        instr_valid <= 1'b0;
        if (next_misaligned) begin
          misaligned <= 1'b1;
        end
      end
    end
  end

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = PC;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: table of fetch transactions driven through a
// memory model, scoreboard of accepted requests, plus reset/trap corner sequences.
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    int          ready_delay;
    int          rsp_delay;
    int          stall;
    bit          spurious;
    logic [31:0] data;
    logic [31:0] pc_next;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] PC_next;
  logic [31:0] PC;
  logic [31:0] PCplus4;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ack;
  logic        misaligned;

  int          n_compared;
  int          n_mismatched;
  logic [31:0] exp_pc;
  sb_t         sb[$];
  vec_t        vecs[6];

  pc_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PC_next       (PC_next),
    .PC            (PC),
    .PCplus4       (PCplus4),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ack     (instr_ack),
    .misaligned    (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " PC"}, PC, 32'h0);
    check({tag, " PCplus4"}, PCplus4, 32'h4);
    check({tag, " instr"}, instr, NOP);
    check({tag, " instr_valid"}, {31'b0, instr_valid}, 32'h0);
    check({tag, " req_valid"}, {31'b0, imem_req_valid}, 32'h0);
    check({tag, " misaligned"}, {31'b0, misaligned}, 32'h0);
  endtask

  // Entered at a negedge with the DUT in REQ for address exp_pc.
  task automatic applyStimulus(input vec_t v);
    sb_t exp;
    bit  got;
    for (int i = 0; i < v.ready_delay; i++) begin
      check("backpressure req_valid", {31'b0, imem_req_valid}, 32'h1);
      check("backpressure req_addr", imem_req_addr, exp_pc);
      imem_req_ready = 1'b0;
      next_cycle();
    end
    check("req_valid", {31'b0, imem_req_valid}, 32'h1);
    check("req_addr", imem_req_addr, exp_pc);
    imem_req_ready = 1'b1;
    sb.push_back('{addr: exp_pc, data: v.data});
    next_cycle();
    imem_req_ready = 1'b0;
    check("wait req_valid", {31'b0, imem_req_valid}, 32'h0);
    for (int j = 0; j < v.rsp_delay; j++) begin
      check("wait instr_valid", {31'b0, instr_valid}, 32'h0);
      next_cycle();
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = v.data;
    next_cycle();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      if (instr_valid) got = 1'b1;
      else next_cycle();
    end
    if (!got) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL instr_valid timeout: got 0, expected 1");
      return;
    end
    checkOutput(exp);
    for (int k = 0; k < v.stall; k++) begin
      if (v.spurious) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hFFFF_FFFF;
      end
      next_cycle();
      check("stall instr", instr, exp.data);
      check("stall instr_valid", {31'b0, instr_valid}, 32'h1);
      check("stall req_valid", {31'b0, imem_req_valid}, 32'h0);
      check("stall PC", PC, exp_pc);
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    PC_next   = v.pc_next;
    instr_ack = 1'b1;
    next_cycle();
    instr_ack = 1'b0;
    exp_pc = v.pc_next;
    check("ack PC", PC, exp_pc);
    check("ack PCplus4", PCplus4, exp_pc + 32'd4);
    check("ack instr_valid", {31'b0, instr_valid}, 32'h0);
    check("ack instr", instr, NOP);
    check("ack misaligned", {31'b0, misaligned}, {31'b0, (exp_pc[1:0] != 2'b00)});
    check("ack req_valid", {31'b0, imem_req_valid}, {31'b0, (exp_pc[1:0] == 2'b00)});
  endtask

  task automatic checkOutput(output sb_t exp);
    if (sb.size() == 0) begin
      n_compared++;
      n_mismatched++;
      exp = '{addr: 32'hx, data: 32'hx};
      $display("[TB] FAIL scoreboard: got instr %h, expected no output", instr);
      return;
    end
    exp = sb.pop_front();
    check("hold instr", instr, exp.data);
    check("hold PC", PC, exp.addr);
    check("hold req_valid", {31'b0, imem_req_valid}, 32'h0);
  endtask

  initial begin
    n_compared     = 0;
    n_mismatched   = 0;
    rst_n          = 1'b0;
    PC_next        = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    instr_ack      = 1'b0;
    exp_pc         = 32'h0;

    vecs[0] = '{ready_delay: 0, rsp_delay: 1, stall: 0, spurious: 0, data: 32'h0050_0093, pc_next: 32'h0000_0004};
    vecs[1] = '{ready_delay: 5, rsp_delay: 0, stall: 3, spurious: 1, data: 32'h00A0_0113, pc_next: 32'h0000_0008};
    vecs[2] = '{ready_delay: 2, rsp_delay: 3, stall: 0, spurious: 0, data: 32'h0020_81B3, pc_next: 32'hFFFF_FFFC};
    vecs[3] = '{ready_delay: 0, rsp_delay: 0, stall: 1, spurious: 0, data: 32'hDEAD_BEEF, pc_next: 32'h0000_0000};
    vecs[4] = '{ready_delay: 1, rsp_delay: 0, stall: 0, spurious: 0, data: 32'h1234_5678, pc_next: 32'h0000_0102};
    vecs[5] = '{ready_delay: 0, rsp_delay: 2, stall: 0, spurious: 0, data: 32'h0010_0073, pc_next: 32'h0000_0010};

    // Held in reset across several clocks.
    repeat (3) next_cycle();
    check_reset_values("reset");

    rst_n = 1'b1;
    #1;
    check("idle req_valid", {31'b0, imem_req_valid}, 32'h0);
    next_cycle();
    check("first req_valid", {31'b0, imem_req_valid}, 32'h1);
    check("first req_addr", imem_req_addr, 32'h0);

    for (int n = 0; n < 5; n++) applyStimulus(vecs[n]);

    // Trap is sticky and ignores handshakes.
    for (int c = 0; c < 10; c++) begin
      instr_ack      = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_req_ready = 1'b1;
      PC_next        = 32'h0000_0040;
      next_cycle();
      check("trap misaligned", {31'b0, misaligned}, 32'h1);
      check("trap instr_valid", {31'b0, instr_valid}, 32'h0);
      check("trap req_valid", {31'b0, imem_req_valid}, 32'h0);
      check("trap PC", PC, 32'h0000_0102);
    end
    instr_ack      = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;

    rst_n = 1'b0;
    #1;
    check_reset_values("trap reset");
    next_cycle();
    rst_n  = 1'b1;
    exp_pc = 32'h0;
    next_cycle();

    // Reset while waiting for a response; the late response must be dropped.
    check("pre-wait req_valid", {31'b0, imem_req_valid}, 32'h1);
    imem_req_ready = 1'b1;
    next_cycle();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("midwait reset");
    @(negedge clk);
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBADB_AD00;
    next_cycle();
    check("late rsp req_valid", {31'b0, imem_req_valid}, 32'h1);
    next_cycle();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    check("late rsp instr_valid", {31'b0, instr_valid}, 32'h0);
    check("late rsp instr", instr, NOP);
    check("restart req_addr", imem_req_addr, 32'h0);

    applyStimulus(vecs[5]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: got hang, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
